wash_sequencer: RTL and testbench
=================================

# wash_sequencer

Parametrised wash-cycle sequencer for the washing-machine controller: runs a per-mode programme of up to four timed phases (soak, wash, rinse, spin) with pause/resume and abort, then holds in a payment state. In that state it accrues an overtime fine in BCD until payment is acknowledged. It sits under `top`, fed by the debounced button pulses and the price/fine registers, and supersedes the fixed-mode wash and billing sequencing.

## Interface
- `MODES`, default 4: number of wash programmes; `MW = $clog2(MODES)`.
- `TICK_DIV`, default 100_000_000: clk cycles per second tick.
- `PHASE_W`, default 8: width of a phase duration in seconds.
- `DIGITS`, default 3: BCD digits of money values.
- `GRACE`, default 10: free seconds in DONE before the fine accrues.
- `DEFAULT_DUR`, default 5: reset value of every duration-table entry.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins the programme `mode_sel`.
- `mode_sel` in MW: programme index.
- `pause` in 1: one-cycle pulse; toggles RUN/PAUSE.
- `abort` in 1: one-cycle pulse; ends the wash early.
- `pay_ok` in 1: one-cycle pulse; acknowledges payment in DONE.
- `price_bcd` in 4*DIGITS: price of `mode_sel`, sampled at start.
- `fine_bcd` in 4*DIGITS: fine per overtime second, sampled every fine tick.
- `cfg_we` in 1: duration-table write strobe.
- `cfg_mode` in MW: table row to write.
- `cfg_phase` in 2: table column to write (0 soak, 1 wash, 2 rinse, 3 spin).
- `cfg_dur` in PHASE_W: duration in seconds to write.
- `state` out 2: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.
- `phase` out 2: active phase.
- `remain_s` out PHASE_W: seconds left in the active phase.
- `charge_bcd` out 4*DIGITS: amount owed.
- `buzzer` out 1: high in DONE once the fine is accruing.
- `paid` out 1: one-cycle pulse on accepted `pay_ok`.

## Operation
- Duration table: MODES×4 entries of PHASE_W bits. All entries reset to DEFAULT_DUR. The table is writable in any state. A phase's duration is read only when that phase is entered.
- Prescaler: counts 0..TICK_DIV-1 and ticks at TICK_DIV-1. It clears on an accepted start, freezes in PAUSE and IDLE, and free-runs in DONE from 0 at entry.
- IDLE: `start` with `mode_sel` < MODES is accepted. On acceptance it latches mode and `price_bcd`, clears `charge_bcd`, and loads the first phase of that mode with nonzero duration. If all four durations are 0 it goes directly to DONE. Otherwise the state becomes RUN. `start` with an out-of-range `mode_sel` is ignored.
- RUN: each tick decrements `remain_s`. A tick with `remain_s`==1 loads the next nonzero phase in the same cycle. If none remains, the state becomes DONE. Zero-duration phases are never visible on `phase`, and `remain_s` never reads 0 in RUN.
- `pause` toggles RUN↔PAUSE. In PAUSE, `remain_s`, `phase` and the prescaler hold.
- `abort` in RUN or PAUSE goes to DONE. The full latched price is charged.
- DONE entry: `charge_bcd` ← latched price and the overtime counter clears. Each tick increments the overtime counter. Ticks after the GRACE-th add `fine_bcd` to `charge_bcd` as a per-digit BCD add. If the sum exceeds all-9s, `charge_bcd` saturates at all-9s. `buzzer` = overtime > GRACE.
- `pay_ok` in DONE: go to IDLE, pulse `paid`, drop `buzzer`. `charge_bcd` holds until the next accepted start.
- Inputs not listed for a state are ignored in that state.
- Priority, for the same cycle: `abort` > `pause` > tick; `pay_ok` > tick. For `pay_ok` plus tick, no fine is added.

## Timing
- Reset values: `state`=0, `phase`=0, `remain_s`=0, `charge_bcd`=0, `buzzer`=0, `paid`=0, prescaler=0, overtime=0.
- Reset mid-operation returns the block to IDLE immediately; the programme is lost.
- Start accepted at edge n: `state`=RUN and `remain_s`=duration at n+1. The first decrement happens TICK_DIV cycles after n.
- All outputs are registered. One-edge latency from input pulse to output.
- A `cfg_we` in the same cycle as a phase load of the same entry loads the old value.

## Test plan
- TICK_DIV=4, durations {2,0,1,3}, start mode 0: phase sequence 0,2,3; RUN lasts 24 cycles, then DONE; `charge_bcd`=price 0x045.
- Pause after 5 cycles of RUN, hold 20 cycles, resume: `remain_s`/`phase` frozen during pause; DONE reached exactly 20 cycles later than unpaused.
- GRACE=2, fine 0x028, price 0x045, wait 5 ticks in DONE: `charge_bcd` 0x045→0x073→0x101→0x129; `buzzer` rises with the first add; `pay_ok` → IDLE, one `paid` pulse, 0x129 held.
- Price 0x990, fine 0x028: saturates at 0x999 and stays there.
- All durations 0 for mode 3, start: DONE one cycle after start. `start` with `mode_sel`≥MODES (MODES=3): no change.
- Abort and pause in the same cycle during RUN: DONE, not PAUSE. Async `rst` during DONE: all outputs reset immediately, table back to DEFAULT_DUR.

Source files
------------

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - per-mode timed wash programme with pause/abort and BCD overtime billing
module wash_sequencer #(
    parameter int MODES       = 4,
    parameter int TICK_DIV    = 100_000_000,
    parameter int PHASE_W     = 8,
    parameter int DIGITS      = 3,
    parameter int GRACE       = 10,
    parameter int DEFAULT_DUR = 5,
    localparam int MW         = (MODES > 1) ? $clog2(MODES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MW-1:0]         mode_sel,
    input  logic                  pause,
    input  logic                  abort,
    input  logic                  pay_ok,
    input  logic [4*DIGITS-1:0]   price_bcd,
    input  logic [4*DIGITS-1:0]   fine_bcd,
    input  logic                  cfg_we,
    input  logic [MW-1:0]         cfg_mode,
    input  logic [1:0]            cfg_phase,
    input  logic [PHASE_W-1:0]    cfg_dur,
    output logic [1:0]            state,
    output logic [1:0]            phase,
    output logic [PHASE_W-1:0]    remain_s,
    output logic [4*DIGITS-1:0]   charge_bcd,
    output logic                  buzzer,
    output logic                  paid
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OW = $clog2(GRACE + 2);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [OW-1:0] GRACE_V   = OW'(GRACE);
    localparam logic [OW-1:0] OT_MAX    = OW'(GRACE + 1);
    localparam logic [PHASE_W-1:0] ONE_S = PHASE_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [3:0][PHASE_W-1:0] row_t;

    state_t              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [PHASE_W-1:0]  remain_q, remain_d;
    logic [MW-1:0]       mode_q, mode_d;
    logic [4*DIGITS-1:0] price_q, price_d;
    logic [4*DIGITS-1:0] charge_q, charge_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [OW-1:0]       ot_q, ot_d;
    logic                buzzer_q, buzzer_d;
    logic                paid_q, paid_d;

    row_t                dur_q [MODES];
    row_t                sel_row;
    row_t                run_row;
    logic                start_ok;
    logic                start_hit;
    logic [1:0]          start_idx;
    logic                next_hit;
    logic [1:0]          next_idx;
    logic                tick;
    logic [PW-1:0]       presc_next;
    logic [4*DIGITS-1:0] fined_charge;

    // Per-digit BCD add; a carry out of the top digit pins the result at all nines.
    function automatic logic [4*DIGITS-1:0] bcd_sat_add(input logic [4*DIGITS-1:0] a,
                                                        input logic [4*DIGITS-1:0] b);
        logic [4*DIGITS-1:0] s;
        logic [4:0]          d;
        logic                c;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
            if (d > 5'd9) begin
                d = d - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s[4*i +: 4] = d[3:0];
        end
        if (c) begin
            s = {DIGITS{4'h9}};
        end
        return s;
    endfunction

    assign start_ok     = ({1'b0, mode_sel} < (MW+1)'(MODES));
    assign tick         = (presc_q == TICK_LAST);
    assign presc_next   = tick ? '0 : presc_q + PW'(1);
    assign fined_charge = bcd_sat_add(charge_q, fine_bcd);

    // Fetch the table row for the requested mode and for the running mode.
    always_comb begin
        sel_row = '0;
        run_row = '0;
        for (int m = 0; m < MODES; m++) begin
            if (MW'(m) == mode_sel) sel_row = dur_q[m];
            if (MW'(m) == mode_q)   run_row = dur_q[m];
        end
    end

    // Find the first nonzero phase of a new programme and the next nonzero phase of the current one.
    always_comb begin
        start_hit = 1'b0;
        start_idx = 2'd0;
        next_hit  = 1'b0;
        next_idx  = 2'd0;
        for (int p = 3; p >= 0; p--) begin
            if (sel_row[p] != '0) begin
                start_hit = 1'b1;
                start_idx = 2'(p);
            end
            if (p > int'(phase_q) && run_row[p] != '0) begin
                next_hit = 1'b1;
                next_idx = 2'(p);
            end
        end
    end

    // Next-state and datapath decisions; abort beats pause beats tick, pay_ok beats tick.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        remain_d = remain_q;
        mode_d   = mode_q;
        price_d  = price_q;
        charge_d = charge_q;
        presc_d  = presc_q;
        ot_d     = ot_q;
        buzzer_d = 1'b0;
        paid_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && start_ok) begin
                    mode_d   = mode_sel;
                    price_d  = price_bcd;
                    charge_d = '0;
                    presc_d  = '0;
                    if (start_hit) begin
                        state_d  = ST_RUN;
                        phase_d  = start_idx;
                        remain_d = sel_row[start_idx];
                    end else begin
                        // Empty programme: straight to billing at the full price.
                        state_d  = ST_DONE;
                        phase_d  = 2'd0;
                        remain_d = '0;
                        charge_d = price_bcd;
                        ot_d     = '0;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d  = ST_DONE;
                    remain_d = '0;
                    charge_d = price_q;
                    presc_d  = '0;
                    ot_d     = '0;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                    presc_d = presc_next;
                end else begin
                    presc_d = presc_next;
                    if (tick) begin
                        if (remain_q == ONE_S) begin
                            if (next_hit) begin
                                phase_d  = next_idx;
                                remain_d = run_row[next_idx];
                            end else begin
                                state_d  = ST_DONE;
                                remain_d = '0;
                                charge_d = price_q;
                                presc_d  = '0;
                                ot_d     = '0;
                            end
                        end else begin
                            remain_d = remain_q - ONE_S;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    state_d  = ST_DONE;
                    remain_d = '0;
                    charge_d = price_q;
                    presc_d  = '0;
                    ot_d     = '0;
                end else if (pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (pay_ok) begin
                    state_d = ST_IDLE;
                    paid_d  = 1'b1;
                end else begin
                    presc_d = presc_next;
                    if (tick) begin
                        ot_d = (ot_q == OT_MAX) ? ot_q : ot_q + OW'(1);
                        if (ot_q >= GRACE_V) begin
                            charge_d = fined_charge;
                        end
                    end
                    buzzer_d = (ot_d > GRACE_V);
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; every output comes straight from one of these.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= 2'd0;
            remain_q <= '0;
            mode_q   <= '0;
            price_q  <= '0;
            charge_q <= '0;
            presc_q  <= '0;
            ot_q     <= '0;
            buzzer_q <= 1'b0;
            paid_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            remain_q <= remain_d;
            mode_q   <= mode_d;
            price_q  <= price_d;
            charge_q <= charge_d;
            presc_q  <= presc_d;
            ot_q     <= ot_d;
            buzzer_q <= buzzer_d;
            paid_q   <= paid_d;
        end
    end

    // Duration table; a same-cycle write and phase load of one entry loads the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < MODES; m++) begin
                dur_q[m] <= {4{PHASE_W'(DEFAULT_DUR)}};
            end
        end else if (cfg_we) begin
            for (int m = 0; m < MODES; m++) begin
                if (MW'(m) == cfg_mode) dur_q[m][cfg_phase] <= cfg_dur;
            end
        end
    end

    assign state      = state_q;
    assign phase      = phase_q;
    assign remain_s   = remain_q;
    assign charge_bcd = charge_q;
    assign buzzer     = buzzer_q;
    assign paid       = paid_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - directed self-checking bench for wash_sequencer
module tb_wash_sequencer;

    localparam int MODES   = 3;
    localparam int MW      = 2;
    localparam int PHASE_W = 8;
    localparam int DIGITS  = 3;

    logic                clk;
    logic                rst;
    logic                start;
    logic [MW-1:0]       mode_sel;
    logic                pause;
    logic                abort;
    logic                pay_ok;
    logic [4*DIGITS-1:0] price_bcd;
    logic [4*DIGITS-1:0] fine_bcd;
    logic                cfg_we;
    logic [MW-1:0]       cfg_mode;
    logic [1:0]          cfg_phase;
    logic [PHASE_W-1:0]  cfg_dur;
    logic [1:0]          state;
    logic [1:0]          phase;
    logic [PHASE_W-1:0]  remain_s;
    logic [4*DIGITS-1:0] charge_bcd;
    logic                buzzer;
    logic                paid;

    int errors = 0;
    int checks = 0;

    wash_sequencer #(
        .MODES(MODES), .TICK_DIV(4), .PHASE_W(PHASE_W), .DIGITS(DIGITS),
        .GRACE(2), .DEFAULT_DUR(5)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode_sel(mode_sel), .pause(pause),
        .abort(abort), .pay_ok(pay_ok), .price_bcd(price_bcd), .fine_bcd(fine_bcd),
        .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_phase(cfg_phase), .cfg_dur(cfg_dur),
        .state(state), .phase(phase), .remain_s(remain_s), .charge_bcd(charge_bcd),
        .buzzer(buzzer), .paid(paid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [MW-1:0] m, input logic [1:0] p, input logic [PHASE_W-1:0] d);
        cfg_we = 1'b1; cfg_mode = m; cfg_phase = p; cfg_dur = d;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        int           run_cycles;
        int           zero_seen;
        int           done_k;
        logic [15:0]  seq;
        logic [3:0]   last_ph;
        logic [31:0]  r3, r4;

        rst = 1'b1; start = 1'b0; mode_sel = '0; pause = 1'b0; abort = 1'b0;
        pay_ok = 1'b0; price_bcd = '0; fine_bcd = 12'h028; cfg_we = 1'b0;
        cfg_mode = '0; cfg_phase = '0; cfg_dur = '0;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("rst_state",  32'(state), 32'd0);
        check("rst_phase",  32'(phase), 32'd0);
        check("rst_remain", 32'(remain_s), 32'd0);
        check("rst_charge", 32'(charge_bcd), 32'd0);
        check("rst_buzzer", 32'(buzzer), 32'd0);
        check("rst_paid",   32'(paid), 32'd0);

        // mode 0 = {2,0,1,3}; mode 2 = all zero; mode 1 keeps defaults
        cfg_write(2'd0, 2'd0, 8'd2);
        cfg_write(2'd0, 2'd1, 8'd0);
        cfg_write(2'd0, 2'd2, 8'd1);
        cfg_write(2'd0, 2'd3, 8'd3);
        for (int p = 0; p < 4; p++) cfg_write(2'd2, 2'(p), 8'd0);

        // plain run of mode 0
        mode_sel = 2'd0; price_bcd = 12'h045; start = 1'b1;
        step();
        start = 1'b0;
        check("a_start_state",  32'(state), 32'd1);
        check("a_start_phase",  32'(phase), 32'd0);
        check("a_start_remain", 32'(remain_s), 32'd2);
        run_cycles = 0; zero_seen = 0; done_k = -1; seq = '0; last_ph = 4'hf; r3 = '0; r4 = '0;
        for (int k = 0; k < 100 && done_k < 0; k++) begin
            if (k > 0) step();
            if (state == 2'd1) begin
                run_cycles++;
                if ({2'b00, phase} != last_ph) begin
                    seq = (seq << 4) | 16'({2'b00, phase} + 4'd1);
                    last_ph = {2'b00, phase};
                end
                if (remain_s == '0) zero_seen++;
            end else if (state == 2'd3) begin
                done_k = k;
            end
            if (k == 3) r3 = 32'(remain_s);
            if (k == 4) r4 = 32'(remain_s);
        end
        check("a_run_cycles",  32'(run_cycles), 32'd24);
        check("a_done_k",      32'(done_k), 32'd24);
        check("a_phase_seq",   32'(seq), 32'h134);
        check("a_zero_remain", 32'(zero_seen), 32'd0);
        check("a_remain_k3",   r3, 32'd2);
        check("a_remain_k4",   r4, 32'd1);
        check("a_done_charge", 32'(charge_bcd), 32'h045);

        // overtime fine accrual with grace of two ticks
        repeat (11) step();
        check("c_charge_11", 32'(charge_bcd), 32'h045);
        check("c_buzzer_11", 32'(buzzer), 32'd0);
        step();
        check("c_charge_12", 32'(charge_bcd), 32'h073);
        check("c_buzzer_12", 32'(buzzer), 32'd1);
        repeat (4) step();
        check("c_charge_16", 32'(charge_bcd), 32'h101);
        repeat (4) step();
        check("c_charge_20", 32'(charge_bcd), 32'h129);
        pay_ok = 1'b1;
        step();
        pay_ok = 1'b0;
        check("c_pay_state",  32'(state), 32'd0);
        check("c_pay_paid",   32'(paid), 32'd1);
        check("c_pay_buzzer", 32'(buzzer), 32'd0);
        check("c_pay_charge", 32'(charge_bcd), 32'h129);
        step();
        check("c_paid_once",  32'(paid), 32'd0);
        repeat (8) step();
        check("c_charge_held", 32'(charge_bcd), 32'h129);

        // pause after 5 RUN cycles for 20 cycles
        mode_sel = 2'd0; price_bcd = 12'h045; start = 1'b1;
        step();
        start = 1'b0;
        check("b_start_charge", 32'(charge_bcd), 32'h000);
        done_k = -1;
        for (int k = 0; k < 120 && done_k < 0; k++) begin
            if (k > 0) step();
            if (k == 6) pause = 1'b0;
            if (k == 26) pause = 1'b0;
            if (k == 6 || k == 25) begin
                check("b_pause_state",  32'(state), 32'd2);
                check("b_pause_remain", 32'(remain_s), 32'd1);
                check("b_pause_phase",  32'(phase), 32'd0);
            end
            if (k == 26) check("b_resume_state", 32'(state), 32'd1);
            if (state == 2'd3) done_k = k;
            if (k == 5 || k == 25) pause = 1'b1;
        end
        pause = 1'b0;
        check("b_done_k", 32'(done_k), 32'd44);
        pay_ok = 1'b1;
        step();
        pay_ok = 1'b0;
        check("b_pay_state", 32'(state), 32'd0);

        // all-zero mode goes straight to DONE; price near the top saturates
        mode_sel = 2'd2; price_bcd = 12'h990; start = 1'b1;
        step();
        start = 1'b0;
        check("s_zero_state",  32'(state), 32'd3);
        check("s_zero_charge", 32'(charge_bcd), 32'h990);
        repeat (11) step();
        check("s_charge_11", 32'(charge_bcd), 32'h990);
        step();
        check("s_charge_12", 32'(charge_bcd), 32'h999);
        check("s_buzzer_12", 32'(buzzer), 32'd1);
        repeat (8) step();
        check("s_charge_20", 32'(charge_bcd), 32'h999);
        pay_ok = 1'b1;
        step();
        pay_ok = 1'b0;

        // out-of-range mode is ignored
        mode_sel = 2'd3; price_bcd = 12'h111; start = 1'b1;
        step();
        start = 1'b0;
        check("o_state",  32'(state), 32'd0);
        check("o_charge", 32'(charge_bcd), 32'h999);
        step();
        check("o_state2", 32'(state), 32'd0);

        // abort and pause together in RUN
        mode_sel = 2'd1; price_bcd = 12'h123; start = 1'b1;
        step();
        start = 1'b0;
        check("x_start_remain", 32'(remain_s), 32'd5);
        repeat (2) step();
        abort = 1'b1; pause = 1'b1;
        step();
        abort = 1'b0; pause = 1'b0;
        check("x_state",  32'(state), 32'd3);
        check("x_charge", 32'(charge_bcd), 32'h123);
        repeat (12) step();
        check("x_charge_12", 32'(charge_bcd), 32'h151);
        check("x_buzzer_12", 32'(buzzer), 32'd1);

        // asynchronous reset in DONE
        #2;
        rst = 1'b1;
        #1;
        check("r_state",  32'(state), 32'd0);
        check("r_charge", 32'(charge_bcd), 32'd0);
        check("r_buzzer", 32'(buzzer), 32'd0);
        step();
        rst = 1'b0;

        // table back to defaults; same-cycle write of the loaded entry loads the old value
        mode_sel = 2'd0; price_bcd = 12'h045; start = 1'b1;
        cfg_we = 1'b1; cfg_mode = 2'd0; cfg_phase = 2'd0; cfg_dur = 8'd9;
        step();
        start = 1'b0; cfg_we = 1'b0;
        check("t_state",  32'(state), 32'd1);
        check("t_phase",  32'(phase), 32'd0);
        check("t_remain", 32'(remain_s), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
